sccb_responder: RTL

//  Camera-side end of the 2-wire SCCB link: decodes SIO_C/SIO_D from the SCCB master.

---
 rtl/sccb_responder_if.sv | 29 ++
 rtl/sccb_responder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sccb_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : sccb_responder_if
//  Brief    : SCCB pad signals plus byte-wide register port of the responder.
//  Revision : 1.0
// ============================================================================
interface sccb_responder_if;
    logic       SIO_C;
    logic       SIO_D_IN;
    logic       SIO_D_OUT;
    logic       SIO_D_OE;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;

    modport slave (
        input  SIO_C, SIO_D_IN, reg_rdata,
        output SIO_D_OUT, SIO_D_OE, reg_addr, reg_wdata, reg_we, reg_re, busy
    );

    modport master (
        output SIO_C, SIO_D_IN, reg_rdata,
        input  SIO_D_OUT, SIO_D_OE, reg_addr, reg_wdata, reg_we, reg_re, busy
    );
endinterface
`default_nettype wire

// File: rtl/sccb_responder.sv
`default_nettype none
// ============================================================================
//  Module   : sccb_responder
//  Brief    : Camera-side SCCB responder: 3/2-phase writes and 2-phase reads.
//  Revision : 1.0
// ============================================================================
module sccb_responder #(
    parameter logic [7:0] DEV_ID      = 8'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  wire logic          XCLK,
    input  wire logic          RST,
    sccb_responder_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ID     = 3'd1,
        S_SUB    = 3'd2,
        S_WDAT   = 3'd3,
        S_RDAT   = 3'd4,
        S_IGNORE = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] r_c_sync;
    logic [SYNC_STAGES-1:0] r_d_sync;
    logic                   r_c_prev;
    logic                   r_d_prev;

    state_t     r_state;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_tx;
    logic       r_oe;
    logic       r_out;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_we;
    logic       r_re;
    logic       r_busy;

    logic w_c;
    logic w_d;
    logic w_start;
    logic w_stop;
    logic w_scl_r;
    logic w_scl_f;

    // Sync flops idle high so reset release never fabricates a bus event.
    always_ff @(posedge XCLK or posedge RST) begin
        if (RST) begin
            r_c_sync <= '1;
            r_d_sync <= '1;
            r_c_prev <= 1'b1;
            r_d_prev <= 1'b1;
        end else begin
            r_c_sync <= {r_c_sync[SYNC_STAGES-2:0], bus.SIO_C};
            r_d_sync <= {r_d_sync[SYNC_STAGES-2:0], bus.SIO_D_IN};
            r_c_prev <= r_c_sync[SYNC_STAGES-1];
            r_d_prev <= r_d_sync[SYNC_STAGES-1];
        end
    end

    assign w_c     = r_c_sync[SYNC_STAGES-1];
    assign w_d     = r_d_sync[SYNC_STAGES-1];
    assign w_start = w_c &  r_c_prev &  r_d_prev & ~w_d;
    assign w_stop  = w_c &  r_c_prev & ~r_d_prev &  w_d;
    assign w_scl_r = w_c & ~r_c_prev;
    assign w_scl_f = ~w_c & r_c_prev;

    always_ff @(posedge XCLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
            r_tx      <= 8'h00;
            r_oe      <= 1'b0;
            r_out     <= 1'b1;
            r_addr    <= 8'h00;
            r_wdata   <= 8'h00;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_we <= 1'b0;
            r_re <= 1'b0;
            if (r_re) begin
                r_tx <= bus.reg_rdata;
            end

            if (w_start) begin
                r_state   <= S_ID;
                r_bit_cnt <= 4'd0;
                r_busy    <= 1'b1;
                r_oe      <= 1'b0;
                r_out     <= 1'b1;
            end else if (w_stop) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= 4'd0;
                r_busy    <= 1'b0;
                r_oe      <= 1'b0;
                r_out     <= 1'b1;
            end else begin
                case (r_state)
                    S_ID, S_SUB, S_WDAT: begin
                        if (w_scl_r) begin
                            if (r_bit_cnt != 4'd8) begin
                                r_shift   <= {r_shift[6:0], w_d};
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end else begin
                                // X bit: the completed byte is acted on here.
                                r_bit_cnt <= 4'd0;
                                case (r_state)
                                    S_ID: begin
                                        if (r_shift == {DEV_ID[7:1], 1'b0}) begin
                                            r_state <= S_SUB;
                                        end else if (r_shift == {DEV_ID[7:1], 1'b1}) begin
                                            r_state <= S_RDAT;
                                            r_re    <= 1'b1;
                                        end else begin
                                            r_state <= S_IGNORE;
                                        end
                                    end
                                    S_SUB: begin
                                        r_addr  <= r_shift;
                                        r_state <= S_WDAT;
                                    end
                                    default: begin
                                        r_wdata <= r_shift;
                                        r_we    <= 1'b1;
                                        r_state <= S_IGNORE;
                                    end
                                endcase
                            end
                        end
                    end
                    S_RDAT: begin
                        // bit_cnt counts bits the master has sampled; 8 means X is next.
                        if (w_scl_f) begin
                            if (r_bit_cnt != 4'd8) begin
                                r_oe  <= 1'b1;
                                r_out <= r_tx[7];
                                r_tx  <= {r_tx[6:0], 1'b0};
                            end else begin
                                r_oe  <= 1'b0;
                                r_out <= 1'b1;
                            end
                        end else if (w_scl_r) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_state   <= S_IGNORE;
                                r_bit_cnt <= 4'd0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    S_IGNORE: begin
                        r_oe  <= 1'b0;
                        r_out <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_oe    <= 1'b0;
                        r_out   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.SIO_D_OE  = r_oe;
    assign bus.SIO_D_OUT = r_out;
    assign bus.reg_addr  = r_addr;
    assign bus.reg_wdata = r_wdata;
    assign bus.reg_we    = r_we;
    assign bus.reg_re    = r_re;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire
